// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, bit-serial shifts (one position per cycle),
// valid/ready handshake on both the request and the result side.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [3:0]       i_ALUControlLines,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_Valid,
    input  logic             i_ResultReady,
    output logic [WIDTH-1:0] o_Result,
    output logic             o_Zero,
    output logic             o_Illegal
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state;
    logic [4:0]       cnt;
    logic             shift_left;
    logic             shift_fill;
    logic [WIDTH-1:0] result_q;
    logic             illegal_q;

    logic [WIDTH-1:0] imm_result;
    logic             imm_illegal;
    logic             is_shift;
    logic [4:0]       shamt;

    assign shamt = i_B[4:0];

    always_comb begin
        imm_result  = '0;
        imm_illegal = 1'b0;
        is_shift    = 1'b0;
        unique case (i_ALUControlLines)
            ALU_ADD:  imm_result = i_A + i_B;
            ALU_SUB:  imm_result = i_A - i_B;
            ALU_SLT:  imm_result = {{(WIDTH-1){1'b0}}, ($signed(i_A) < $signed(i_B))};
            ALU_SLTU: imm_result = {{(WIDTH-1){1'b0}}, (i_A < i_B)};
            ALU_AND:  imm_result = i_A & i_B;
            ALU_OR:   imm_result = i_A | i_B;
            ALU_XOR:  imm_result = i_A ^ i_B;
            ALU_LUI:  imm_result = i_B;
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                // Operand A seeds the shift register; shamt 0 completes as-is.
                imm_result = i_A;
                is_shift   = 1'b1;
            end
            default:  imm_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state      <= IDLE;
            cnt        <= '0;
            shift_left <= 1'b0;
            shift_fill <= 1'b0;
            result_q   <= '0;
            illegal_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_Valid) begin
                        result_q   <= imm_result;
                        illegal_q  <= imm_illegal;
                        shift_left <= (i_ALUControlLines == ALU_SLL);
                        shift_fill <= (i_ALUControlLines == ALU_SRA) & i_A[WIDTH-1];
                        if (is_shift && shamt != 5'd0) begin
                            cnt   <= shamt;
                            state <= SHIFT;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (shift_left)
                        result_q <= {result_q[WIDTH-2:0], 1'b0};
                    else
                        result_q <= {shift_fill, result_q[WIDTH-1:1]};
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1)
                        state <= DONE;
                end
                DONE: begin
                    if (i_ResultReady)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_Ready   = (state == IDLE);
    assign o_Valid   = (state == DONE);
    assign o_Result  = result_q;
    assign o_Illegal = illegal_q;
    assign o_Zero    = (result_q == '0);

endmodule
